// File: rtl/data_mem_arbiter_if.sv
// Requester, memory and GPIO signal bundle for data_mem_arbiter.
// master: requesters plus memory side; slave: the arbiter.
interface data_mem_arbiter_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          cpu_req;
    logic          cpu_we;
    logic          cpu_sb;
    logic          cpu_lb;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ack;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] gpio_out;

    modport master (
        output cpu_req, cpu_we, cpu_sb, cpu_lb, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  gpio_out
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_sb, cpu_lb, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output gpio_out
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU and debug access to the synchronous-read data memory and GPIO register.
// DMARB_DBG_PORT_EN enables the debug port and round-robin; otherwise the CPU always wins.
module data_mem_arbiter #(
    parameter logic [31:0] GPIO_ADDR = 32'h0000ABCD
) (
    input logic           clock,
    input logic           reset,
    data_mem_arbiter_if.slave bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, MERGE_WR} state_t;

    state_t        state;
    logic          op_we;
    logic          op_sb;
    logic          op_lb;
    logic          op_gpio;
    logic [1:0]    op_bsel;
    logic [DW-1:0] op_wdata;

    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_we_q;
    logic [DW-1:0] gpio_q;
    logic          cpu_ack_q;
    logic [DW-1:0] cpu_rdata_q;

    logic          cpu_ok;
    logic          grant_dbg;
    logic          any_req;
    logic          sel_we;
    logic          sel_sb;
    logic          sel_lb;
    logic          sel_gpio;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          done;
    logic [DW-1:0] done_data;
    logic [DW-1:0] merged;
    logic [BW-1:0] lb_byte;

`ifdef DMARB_DBG_PORT_EN
    logic          last_dbg;
    logic          op_dbg;
    logic          dbg_ok;
    logic          dbg_ack_q;
    logic [DW-1:0] dbg_rdata_q;
`else
    logic unused_dbg;
    assign unused_dbg = ^{bus.dbg_req, bus.dbg_we, bus.dbg_addr, bus.dbg_wdata};
`endif

    // Winner selection; a port whose ack is on the bus this cycle is not re-accepted.
    always_comb begin
        cpu_ok    = bus.cpu_req & ~cpu_ack_q;
        grant_dbg = 1'b0;
`ifdef DMARB_DBG_PORT_EN
        dbg_ok    = bus.dbg_req & ~dbg_ack_q;
        grant_dbg = dbg_ok & (~cpu_ok | ~last_dbg);
`endif
        any_req   = cpu_ok | grant_dbg;
        sel_we    = bus.cpu_we;
        sel_sb    = bus.cpu_sb;
        sel_lb    = bus.cpu_lb;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
`ifdef DMARB_DBG_PORT_EN
        if (grant_dbg) begin
            sel_we    = bus.dbg_we;
            sel_sb    = 1'b0;
            sel_lb    = 1'b0;
            sel_addr  = bus.dbg_addr;
            sel_wdata = bus.dbg_wdata;
        end
`endif
        sel_gpio = (sel_addr[AW-1:2] == GPIO_ADDR[AW-1:2]);
    end

    // Completion decode plus byte extract / byte merge on the returned memory word.
    always_comb begin
        lb_byte = bus.mem_rdata[{op_bsel, 3'b000} +: BW];
        merged  = bus.mem_rdata;
        merged[{op_bsel, 3'b000} +: BW] = op_wdata[BW-1:0];
        done      = 1'b0;
        done_data = bus.mem_rdata;
        case (state)
            ACCESS: begin
                done      = op_gpio | (op_we & ~op_sb);
                done_data = gpio_q;
            end
            WAIT: begin
                done      = ~op_we;
                done_data = op_lb ? DW'(lb_byte) : bus.mem_rdata;
            end
            MERGE_WR: done = 1'b1;
            default:  done = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            op_we       <= 1'b0;
            op_sb       <= 1'b0;
            op_lb       <= 1'b0;
            op_gpio     <= 1'b0;
            op_bsel     <= 2'b00;
            op_wdata    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            gpio_q      <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
`ifdef DMARB_DBG_PORT_EN
            last_dbg    <= 1'b1;
            op_dbg      <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
`endif
        end else begin
            cpu_ack_q <= 1'b0;
            mem_we_q  <= 1'b0;
`ifdef DMARB_DBG_PORT_EN
            dbg_ack_q <= 1'b0;
`endif
            // Ack goes only to the port that owns the access; rdata updates on reads only.
            if (done) begin
`ifdef DMARB_DBG_PORT_EN
                if (op_dbg) begin
                    dbg_ack_q <= 1'b1;
                    if (!op_we) dbg_rdata_q <= done_data;
                end else
`endif
                begin
                    cpu_ack_q <= 1'b1;
                    if (!op_we) cpu_rdata_q <= done_data;
                end
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_we       <= sel_we;
                        op_sb       <= sel_sb & ~sel_gpio;
                        op_lb       <= sel_lb & ~sel_gpio;
                        op_gpio     <= sel_gpio;
                        op_bsel     <= sel_addr[1:0];
                        op_wdata    <= sel_wdata;
                        mem_addr_q  <= {sel_addr[AW-1:2], 2'b00};
                        mem_wdata_q <= sel_wdata;
                        mem_we_q    <= sel_we & ~sel_sb & ~sel_gpio;
`ifdef DMARB_DBG_PORT_EN
                        op_dbg      <= grant_dbg;
                        last_dbg    <= grant_dbg;
`endif
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (op_gpio && op_we) gpio_q <= op_wdata;
                    state <= done ? IDLE : WAIT;
                end
                WAIT: begin
                    if (op_we) begin
                        mem_wdata_q <= merged;
                        mem_we_q    <= 1'b1;
                        state       <= MERGE_WR;
                    end else begin
                        state <= IDLE;
                    end
                end
                MERGE_WR: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.gpio_out  = gpio_q;
`ifdef DMARB_DBG_PORT_EN
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.dbg_rdata = dbg_rdata_q;
`else
    assign bus.dbg_ack   = 1'b0;
    assign bus.dbg_rdata = '0;
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a synchronous-read memory model.
module tb_data_mem_arbiter;
    localparam logic [31:0] GPIO_A = 32'h0000ABCD;

    typedef struct {
        bit          dbg;
        bit          chk;
        logic [31:0] data;
        int          ack_cyc;
        string       name;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          we_cnt = 0;
    int          w0 = 0;
    exp_t        sbq[$];
    logic [31:0] mem [0:255];

    data_mem_arbiter_if bus();

    data_mem_arbiter #(.GPIO_ADDR(GPIO_A)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read memory: data for mem_addr appears one cycle later.
    always @(posedge clock) begin
        bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        if (bus.mem_we === 1'b1) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
    end

    always @(negedge clock) if (bus.mem_we === 1'b1) we_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit dbg, input bit chk, input logic [31:0] data, input int off,
                        input string name);
        exp_t e;
        e.dbg = dbg; e.chk = chk; e.data = data; e.ack_cyc = cyc + off; e.name = name;
        sbq.push_back(e);
    endtask

    // Monitor: every ack pops the oldest expectation and checks port, latency and data.
    always @(negedge clock) begin : monitor
        exp_t e;
        bit   is_dbg;
        if (bus.cpu_ack === 1'b1 || bus.dbg_ack === 1'b1) begin
            is_dbg = (bus.dbg_ack === 1'b1);
            if (bus.cpu_ack === 1'b1 && is_dbg) begin
                n_cmp++; n_fail++;
                $display("FAIL dual_ack: both ports acked at cycle %0d, expected one", cyc);
            end
            if (sbq.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_ack: ack on %s port at cycle %0d, expected none",
                         is_dbg ? "dbg" : "cpu", cyc);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_port"}, 32'(is_dbg), 32'(e.dbg));
                check({e.name, "_latency"}, 32'(cyc), 32'(e.ack_cyc));
                if (e.chk) check({e.name, "_rdata"}, is_dbg ? bus.dbg_rdata : bus.cpu_rdata, e.data);
            end
        end
    end

    task automatic cpu_go(input bit we, input bit sb, input bit lb, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bus.cpu_we = we; bus.cpu_sb = sb; bus.cpu_lb = lb;
        bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
    endtask

    task automatic cpu_wait(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (bus.cpu_ack === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: cpu_ack absent after 20 cycles, expected a pulse", name);
        end else begin
            check({name, "_stall_at_ack"}, 32'(bus.cpu_stall), 32'd0);
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic cpu_op(input string name, input bit we, input bit sb, input bit lb,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit chk,
                          input logic [31:0] exp, input int off);
        @(negedge clock);
        push(1'b0, chk, exp, off, name);
        cpu_go(we, sb, lb, addr, wdata);
        #1 check({name, "_stall"}, 32'(bus.cpu_stall), 32'd1);
        cpu_wait(name);
    endtask

`ifdef DMARB_DBG_PORT_EN
    task automatic dbg_go(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata; bus.dbg_req = 1'b1;
    endtask

    task automatic dbg_wait(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (bus.dbg_ack === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: dbg_ack absent after 20 cycles, expected a pulse", name);
        end
        bus.dbg_req = 1'b0;
    endtask

    task automatic dbg_op(input string name, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit chk, input logic [31:0] exp,
                          input int off);
        @(negedge clock);
        push(1'b1, chk, exp, off, name);
        dbg_go(we, addr, wdata);
        dbg_wait(name);
    endtask
`endif

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_sb = 1'b0; bus.cpu_lb = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8] = 32'h11223344;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_cpu_ack",   32'(bus.cpu_ack), 32'd0);
        check("rst_dbg_ack",   32'(bus.dbg_ack), 32'd0);
        check("rst_mem_we",    32'(bus.mem_we),  32'd0);
        check("rst_mem_addr",  bus.mem_addr,     32'h0);
        check("rst_mem_wdata", bus.mem_wdata,    32'h0);
        check("rst_cpu_rdata", bus.cpu_rdata,    32'h0);
        check("rst_dbg_rdata", bus.dbg_rdata,    32'h0);
        check("rst_gpio",      bus.gpio_out,     32'h0);

`ifdef DMARB_DBG_PORT_EN
        // Simultaneous requests straight out of reset: CPU first, debug right after.
        @(negedge clock);
        push(1'b0, 1'b0, 32'h0, 2, "sim1_cpu");
        push(1'b1, 1'b0, 32'h0, 4, "sim1_dbg");
        cpu_go(1'b1, 1'b0, 1'b0, 32'h40, 32'hCAFE0001);
        dbg_go(1'b1, 32'h44, 32'hCAFE0002);
        fork
            cpu_wait("sim1_cpu");
            dbg_wait("sim1_dbg");
        join
        check("sim1_mem40", mem[16], 32'hCAFE0001);
        check("sim1_mem44", mem[17], 32'hCAFE0002);
`else
        // Debug port is absent: a held request must never be served.
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1;
        bus.dbg_addr = 32'h60; bus.dbg_wdata = 32'hBAD0BAD0;
`endif

        // Word write then word read.
        @(negedge clock);
        push(1'b0, 1'b0, 32'h0, 2, "wr10");
        cpu_go(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
        #1 check("wr10_stall", 32'(bus.cpu_stall), 32'd1);
        @(posedge clock); #1;
        check("wr10_mem_we",    32'(bus.mem_we), 32'd1);
        check("wr10_mem_addr",  bus.mem_addr,    32'h10);
        check("wr10_mem_wdata", bus.mem_wdata,   32'hDEADBEEF);
        cpu_wait("wr10");
        cpu_op("rd10", 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 3);

        // Store byte read-modify-write, then load bytes across lanes.
        @(negedge clock);
        push(1'b0, 1'b0, 32'h0, 4, "sb22");
        cpu_go(1'b1, 1'b1, 1'b0, 32'h22, 32'h000000AA);
        @(posedge clock); #1 check("sb22_we_access", 32'(bus.mem_we), 32'd0);
        @(posedge clock); #1 check("sb22_we_wait",   32'(bus.mem_we), 32'd0);
        @(posedge clock); #1;
        check("sb22_we_merge",    32'(bus.mem_we), 32'd1);
        check("sb22_merge_addr",  bus.mem_addr,    32'h20);
        check("sb22_merge_wdata", bus.mem_wdata,   32'h11AA3344);
        check("sb22_stall",       32'(bus.cpu_stall), 32'd1);
        cpu_wait("sb22");
        check("sb22_mem", mem[8], 32'h11AA3344);
        cpu_op("lb23", 1'b0, 1'b0, 1'b1, 32'h23, 32'h0, 1'b1, 32'h00000011, 3);
        cpu_op("lb22", 1'b0, 1'b0, 1'b1, 32'h22, 32'h0, 1'b1, 32'h000000AA, 3);
        cpu_op("lb20", 1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 32'h00000044, 3);

        // GPIO accesses never touch memory; sb/lb qualifiers are ignored there.
        w0 = we_cnt;
        @(negedge clock);
        push(1'b0, 1'b0, 32'h0, 2, "gpio_wr");
        cpu_go(1'b1, 1'b0, 1'b0, GPIO_A, 32'h00005A5A);
        @(posedge clock);
        @(posedge clock); #1 check("gpio_wr_value", bus.gpio_out, 32'h00005A5A);
        cpu_wait("gpio_wr");
        cpu_op("gpio_rd", 1'b0, 1'b0, 1'b0, GPIO_A, 32'h0, 1'b1, 32'h00005A5A, 2);
        cpu_op("gpio_lb", 1'b0, 1'b0, 1'b1, GPIO_A, 32'h0, 1'b1, 32'h00005A5A, 2);
        cpu_op("gpio_sb", 1'b1, 1'b1, 1'b0, GPIO_A, 32'h000012FF, 1'b0, 32'h0, 2);
        cpu_op("gpio_rd2", 1'b0, 1'b0, 1'b0, GPIO_A, 32'h0, 1'b1, 32'h000012FF, 2);
        check("gpio_no_mem_we", 32'(we_cnt), 32'(w0));

`ifdef DMARB_DBG_PORT_EN
        // Last winner was the CPU, so debug wins this tie.
        @(negedge clock);
        push(1'b1, 1'b0, 32'h0, 2, "sim2_dbg");
        push(1'b0, 1'b0, 32'h0, 4, "sim2_cpu");
        dbg_go(1'b1, 32'h48, 32'h0000D0D0);
        cpu_go(1'b1, 1'b0, 1'b0, 32'h4C, 32'h0000C0C0);
        fork
            cpu_wait("sim2_cpu");
            dbg_wait("sim2_dbg");
        join
        dbg_op("dbg_rd44", 1'b0, 32'h44, 32'h0, 1'b1, 32'hCAFE0002, 3);
        @(negedge clock);
        check("dbg_rdata_hold", bus.dbg_rdata, 32'hCAFE0002);
        cpu_op("rd48", 1'b0, 1'b0, 1'b0, 32'h48, 32'h0, 1'b1, 32'h0000D0D0, 3);
        cpu_op("rd4c", 1'b0, 1'b0, 1'b0, 32'h4C, 32'h0, 1'b1, 32'h0000C0C0, 3);
`endif

        // Reset during the WAIT of a store byte aborts the RMW.
        @(negedge clock);
        w0 = we_cnt;
        cpu_go(1'b1, 1'b1, 1'b0, 32'h21, 32'h00000055);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clock); #1;
        check("abort_cpu_ack",   32'(bus.cpu_ack), 32'd0);
        check("abort_dbg_ack",   32'(bus.dbg_ack), 32'd0);
        check("abort_mem_we",    32'(bus.mem_we),  32'd0);
        check("abort_mem_addr",  bus.mem_addr,     32'h0);
        check("abort_mem_wdata", bus.mem_wdata,    32'h0);
        check("abort_cpu_rdata", bus.cpu_rdata,    32'h0);
        check("abort_dbg_rdata", bus.dbg_rdata,    32'h0);
        check("abort_gpio",      bus.gpio_out,     32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("abort_no_mem_we", 32'(we_cnt), 32'(w0));
        check("abort_mem_kept",  mem[8], 32'h11AA3344);
        cpu_op("rd20", 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 32'h11AA3344, 3);

`ifndef DMARB_DBG_PORT_EN
        check("nodbg_mem60", mem[24], 32'h0);
        check("nodbg_rdata", bus.dbg_rdata, 32'h0);
        bus.dbg_req = 1'b0;
`endif

        repeat (2) @(negedge clock);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-ported data memory and the GPIO output register between two requesters: the CPU memory stage and a debug/loader port. It arbitrates, sequences each access over the synchronous-read memory, and performs load-byte extraction and store-byte read-modify-write. It sits between the memory-stage control signals and the data memory, and stalls the CPU pipeline while its access is pending.

## Interface

**Parameters**
- `GPIO_ADDR`, default 32'h0000ABCD: word address decoded as the GPIO output register instead of memory.

**Ports**
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  in  1  write (1) / read (0).
- `cpu_sb`  in  1  store byte (qualifies write).
- `cpu_lb`  in  1  load byte (qualifies read).
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  write data.
- `cpu_rdata`  out  32  read data, valid while `cpu_ack`=1.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`, combinational.
- `dbg_req`, `dbg_we`, `dbg_addr[31:0]`, `dbg_wdata[31:0]`  in  debug requester; word accesses only.
- `dbg_rdata`  out  32  and `dbg_ack`  out  1  same rules as the CPU port.
- `mem_addr`  out  32  memory byte address, bits [1:0] forced to 00.
- `mem_wdata`  out  32  memory write data.
- `mem_we`  out  1  memory write strobe.
- `mem_rdata`  in  32  memory read data, valid one cycle after `mem_addr`.
- `gpio_out`  out  32  GPIO output register.

## Operation

- FSM states: IDLE, ACCESS, WAIT, MERGE_WR.
- IDLE: if any request is present, choose a winner, latch its op/addr/wdata, and go to ACCESS. With no request, stay in IDLE.
- Arbitration is round-robin. A `last` pointer records the previous winner. When both ports request, the port not granted last wins. A single requester always wins.
- ACCESS, GPIO address (`addr[31:2]`==`GPIO_ADDR[31:2]`):
  - Write loads `gpio_out` with wdata; read returns `gpio_out`.
  - Ack is issued, then go to IDLE. `mem_we`=0.
  - sb/lb are ignored for GPIO accesses.
- ACCESS, word write: `mem_we`=1, ack, then go to IDLE.
- ACCESS, read or store byte: `mem_we`=0, then go to WAIT.
- WAIT, read: rdata = `mem_rdata`. With lb, rdata = the byte selected by `addr[1:0]`, zero-extended (00 selects bits [7:0], 11 selects bits [31:24]). Ack, then go to IDLE.
- WAIT, store byte: merge `wdata[7:0]` into the byte lane selected by `addr[1:0]` of `mem_rdata`, then go to MERGE_WR.
- MERGE_WR: `mem_we`=1 with the merged word, ack, then go to IDLE.
- The latched request fields are used for the whole access; changes on the inputs mid-access are ignored.
- `rdata` outputs hold their last value when ack=0. Only the granted port sees ack.

## Timing

- Latency is counted from the IDLE edge that accepts the request to ack high:
  - word write and GPIO access: 1 cycle;
  - word read: 2 cycles;
  - store byte: 3 cycles.
- After ack the FSM is in IDLE, so back-to-back requests lose one cycle.
- Reset values: state=IDLE, `last`=debug (so the CPU wins the first tie), `gpio_out`=0, all acks=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, all rdata=0.
- Reset mid-access aborts it: no `mem_we`, no ack, and a store-byte RMW is never written.
- A requester that drops req before ack has undefined access completion. Ack is still issued, and the bench must not rely on it.

## Configuration

- `DMARB_DBG_PORT_EN` defined: the debug port and round-robin arbitration are present.
- `DMARB_DBG_PORT_EN` undefined: all `dbg_*` inputs are ignored, `dbg_ack`/`dbg_rdata` are tied to 0, the CPU is always the winner, and the `last` pointer is removed. CPU timing is unchanged.

## Test plan

- CPU word write 32'hDEADBEEF to 0x10, then read 0x10 → `mem_we` high in the cycle after acceptance; read ack 2 cycles after acceptance with `cpu_rdata`=32'hDEADBEEF; `cpu_stall` high until ack.
- Memory word 0x11223344 at 0x20: sb wdata 0xAA at 0x22 → merged write 0x11AA3344 with ack 3 cycles after acceptance; lb at 0x23 → 0x00000011.
- `cpu_req` and `dbg_req` asserted together from reset → CPU served first, debug next. Repeat the simultaneous request → debug served first (alternation).
- CPU write 0x5A5A to `GPIO_ADDR` → `gpio_out`=0x5A5A one cycle after acceptance, `mem_we` never asserted; read `GPIO_ADDR` → 0x5A5A.
- `reset` pulsed during WAIT of a store byte → no `mem_we`, no ack, all outputs at reset values the next cycle; memory word unchanged.
- Build without `DMARB_DBG_PORT_EN`, hold `dbg_req`=1 → `dbg_ack` never asserts and CPU latencies match scenario 1.
